// File: rtl/div16_seq_if.sv
// Handshake and operand/result bundle between the execute stage and the divider.
interface div16_seq_if #(
    parameter int unsigned N = 16
);
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/div16_seq.sv
// Iterative unsigned restoring divider: one quotient bit per clock, N+1 cycle latency.
module div16_seq #(
    parameter int unsigned N = 16
) (
    input  logic        clk,
    input  logic        rst,
    div16_seq_if.slave  bus
);
    localparam int unsigned CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        r_state;
    logic [N-1:0]  r_rem;
    logic [N-1:0]  r_q;
    logic [N-1:0]  r_dvsr;
    logic [CW-1:0] r_cnt;
    logic          r_busy;
    logic          r_done;
    logic [N-1:0]  r_quot;
    logic [N-1:0]  r_remout;
    logic          r_dbz;

    logic [N:0]    w_shift;
    logic [N:0]    w_trial;
    logic [N-1:0]  w_rem_next;
    logic [N-1:0]  w_q_next;

    // R[N] is always 0 between iterations, so only N bits of R are stored.
    always_comb begin
        w_shift    = {r_rem, r_q[N-1]};
        w_trial    = w_shift - {1'b0, r_dvsr};
        w_rem_next = w_shift[N-1:0];
        w_q_next   = {r_q[N-2:0], 1'b0};
        if (!w_trial[N]) begin
            w_rem_next = w_trial[N-1:0];
            w_q_next   = {r_q[N-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_rem    <= '0;
            r_q      <= '0;
            r_dvsr   <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_quot   <= '0;
            r_remout <= '0;
            r_dbz    <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                    if (bus.start) begin
                        r_dvsr <= bus.divisor;
                        if (bus.divisor == '0) begin
                            r_state  <= DONE;
                            r_done   <= 1'b1;
                            r_quot   <= '1;
                            r_remout <= bus.dividend;
                            r_dbz    <= 1'b1;
                        end else begin
                            r_state <= RUN;
                            r_busy  <= 1'b1;
                            r_rem   <= '0;
                            r_q     <= bus.dividend;
                            r_cnt   <= CW'(N);
                            r_quot  <= '0;
                            r_dbz   <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    r_rem <= w_rem_next;
                    r_q   <= w_q_next;
                    r_cnt <= r_cnt - CW'(1);
                    // Results are captured on the edge entering DONE, from the final iteration.
                    if (r_cnt == CW'(1)) begin
                        r_state  <= DONE;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_quot   <= w_q_next;
                        r_remout <= w_rem_next;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.quotient    = r_quot;
    assign bus.remainder   = r_remout;
    assign bus.div_by_zero = r_dbz;
endmodule
